// File: rtl/fsm_transition_monitor_pkg.sv
// fsm_transition_monitor_pkg: shared types, defaults and arc indexing for the transition monitor
package fsm_transition_monitor_pkg;
  localparam int DEF_STATE_W = 2;
  localparam int DEF_NUM_STATES = 4;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_STUCK_LIMIT = 200;
  typedef enum logic {EMPTY, TRACK} mon_state_t;
  typedef struct packed {
    logic [DEF_STATE_W-1:0] from_s;
    logic [DEF_STATE_W-1:0] to_s;
  } arc_t;
  function automatic int arc_index(int f, int t, int n);
    return f * n + t;
  endfunction
endpackage

// File: rtl/fsm_transition_monitor_if.sv
// fsm_transition_monitor_if: observed-state inputs and decoded transition outputs
interface fsm_transition_monitor_if
  import fsm_transition_monitor_pkg::*;
#(
  parameter int STATE_W = DEF_STATE_W,
  parameter int NUM_STATES = DEF_NUM_STATES,
  parameter int CNT_W = DEF_CNT_W
);
  logic sample_valid;
  logic [STATE_W-1:0] state_in;
  logic [NUM_STATES*NUM_STATES-1:0] legal_mask;
  logic clear;
  logic trans_valid;
  logic [STATE_W-1:0] trans_from;
  logic [STATE_W-1:0] trans_to;
  logic illegal;
  logic illegal_sticky;
  logic [STATE_W-1:0] first_bad_from;
  logic [STATE_W-1:0] first_bad_to;
  logic [CNT_W-1:0] dwell_count;
  logic [CNT_W-1:0] trans_count;
  logic stuck;
  modport master (
    output sample_valid, state_in, legal_mask, clear,
    input trans_valid, trans_from, trans_to, illegal, illegal_sticky,
    input first_bad_from, first_bad_to, dwell_count, trans_count, stuck
  );
  modport slave (
    input sample_valid, state_in, legal_mask, clear,
    output trans_valid, trans_from, trans_to, illegal, illegal_sticky,
    output first_bad_from, first_bad_to, dwell_count, trans_count, stuck
  );
endinterface

// File: rtl/fsm_transition_monitor_sat_counter.sv
// sat_counter: saturating up-counter; clr restarts at 0, or at 1 when inc coincides
module sat_counter #(
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic [W-1:0] value
);
  // clear wins but still counts a same-cycle increment
  always_ff @(posedge clk)
    if (rst) value <= '0;
    else if (clr) value <= W'(inc);
    else if (inc && value != '1) value <= value + 1'b1;
endmodule

// File: rtl/fsm_transition_monitor.sv
// fsm_transition_monitor: decodes an observed FSM state bus into checked transition events
module fsm_transition_monitor
  import fsm_transition_monitor_pkg::*;
#(
  parameter int STATE_W = DEF_STATE_W,
  parameter int NUM_STATES = DEF_NUM_STATES,
  parameter int CNT_W = DEF_CNT_W,
  parameter int STUCK_LIMIT = DEF_STUCK_LIMIT
) (
  input logic clk,
  input logic rst,
  fsm_transition_monitor_if.slave m
);
  localparam int IW = $clog2(NUM_STATES * NUM_STATES);
  mon_state_t mon_st;
  logic [STATE_W-1:0] prev_state;
  logic tracking, in_range, prev_in_range, is_trans, bad_arc, ill_now;
  logic dwell_inc, dwell_clr;
  logic [IW-1:0] idx;
  arc_t cur_arc;
  // decode the current sample against the held reference state
  always_comb begin
    tracking = mon_st == TRACK;
    in_range = int'(m.state_in) < NUM_STATES;
    prev_in_range = int'(prev_state) < NUM_STATES;
    is_trans = m.sample_valid && tracking && m.state_in != prev_state;
    idx = IW'(arc_index(int'(prev_state), int'(m.state_in), NUM_STATES));
    bad_arc = !prev_in_range || !m.legal_mask[idx];
    ill_now = m.sample_valid && (!in_range || (is_trans && bad_arc));
    cur_arc.from_s = tracking ? prev_state : m.state_in;
    cur_arc.to_s = m.state_in;
    dwell_inc = m.sample_valid && tracking && !is_trans && !m.clear;
    dwell_clr = m.clear || (m.sample_valid && !tracking) || is_trans;
  end
  sat_counter #(.W(CNT_W)) u_dwell (
    .clk(clk), .rst(rst), .inc(dwell_inc), .clr(dwell_clr), .value(m.dwell_count)
  );
  sat_counter #(.W(CNT_W)) u_trans (
    .clk(clk), .rst(rst), .inc(is_trans), .clr(m.clear), .value(m.trans_count)
  );
  assign m.stuck = m.dwell_count >= CNT_W'(STUCK_LIMIT);
  // reference tracking, registered pulses and first-illegal capture
  always_ff @(posedge clk)
    if (rst) begin
      mon_st <= EMPTY;
      prev_state <= '0;
      m.trans_valid <= 1'b0;
      m.trans_from <= '0;
      m.trans_to <= '0;
      m.illegal <= 1'b0;
      m.illegal_sticky <= 1'b0;
      m.first_bad_from <= '0;
      m.first_bad_to <= '0;
    end else begin
      if (m.sample_valid) begin
        mon_st <= TRACK;
        prev_state <= m.state_in;
      end
      m.trans_valid <= is_trans;
      m.illegal <= ill_now;
      if (is_trans) begin
        m.trans_from <= prev_state;
        m.trans_to <= m.state_in;
      end
      if (m.clear || (ill_now && !m.illegal_sticky)) begin
        m.illegal_sticky <= ill_now;
        m.first_bad_from <= ill_now ? cur_arc.from_s : '0;
        m.first_bad_to <= ill_now ? cur_arc.to_s : '0;
      end
    end
endmodule

// File: tb/tb_fsm_transition_monitor.sv
// tb_fsm_transition_monitor: table-driven and sequence checks of the transition monitor
module tb_fsm_transition_monitor;
  typedef struct {
    int sv, st, clr, tv, fr, to, ill, stk, bf, bt, dw, tc;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  vec_t vecs[11];
  fsm_transition_monitor_if bus ();
  fsm_transition_monitor dut (.clk(clk), .rst(rst), .m(bus.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic check_zero(input string tag);
    chk({tag, " trans_valid"}, 32'(bus.trans_valid), 0);
    chk({tag, " trans_from"}, 32'(bus.trans_from), 0);
    chk({tag, " trans_to"}, 32'(bus.trans_to), 0);
    chk({tag, " illegal"}, 32'(bus.illegal), 0);
    chk({tag, " illegal_sticky"}, 32'(bus.illegal_sticky), 0);
    chk({tag, " first_bad_from"}, 32'(bus.first_bad_from), 0);
    chk({tag, " first_bad_to"}, 32'(bus.first_bad_to), 0);
    chk({tag, " dwell_count"}, 32'(bus.dwell_count), 0);
    chk({tag, " trans_count"}, 32'(bus.trans_count), 0);
    chk({tag, " stuck"}, 32'(bus.stuck), 0);
  endtask
  initial begin
    int seen;
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[2]  = '{1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1};
    vecs[3]  = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1};
    vecs[4]  = '{1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2};
    vecs[5]  = '{1, 3, 0, 1, 0, 3, 1, 1, 0, 3, 0, 3};
    vecs[6]  = '{1, 2, 0, 1, 3, 2, 1, 1, 0, 3, 0, 4};
    vecs[7]  = '{0, 1, 0, 0, 3, 2, 0, 1, 0, 3, 0, 4};
    vecs[8]  = '{1, 1, 0, 1, 2, 1, 0, 1, 0, 3, 0, 5};
    vecs[9]  = '{1, 2, 1, 1, 1, 2, 0, 0, 0, 0, 0, 1};
    vecs[10] = '{1, 2, 0, 0, 1, 2, 0, 0, 0, 0, 1, 1};
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    bus.state_in = 2'd0;
    bus.clear = 1'b0;
    bus.legal_mask = 16'hBFF7;
    tick();
    tick();
    check_zero("reset");
    rst = 1'b0;
    for (int i = 0; i < 11; i++) begin
      bus.sample_valid = 1'(vecs[i].sv);
      bus.state_in = 2'(vecs[i].st);
      bus.clear = 1'(vecs[i].clr);
      tick();
      chk($sformatf("v%0d trans_valid", i), 32'(bus.trans_valid), vecs[i].tv);
      chk($sformatf("v%0d trans_from", i), 32'(bus.trans_from), vecs[i].fr);
      chk($sformatf("v%0d trans_to", i), 32'(bus.trans_to), vecs[i].to);
      chk($sformatf("v%0d illegal", i), 32'(bus.illegal), vecs[i].ill);
      chk($sformatf("v%0d illegal_sticky", i), 32'(bus.illegal_sticky), vecs[i].stk);
      chk($sformatf("v%0d first_bad_from", i), 32'(bus.first_bad_from), vecs[i].bf);
      chk($sformatf("v%0d first_bad_to", i), 32'(bus.first_bad_to), vecs[i].bt);
      chk($sformatf("v%0d dwell_count", i), 32'(bus.dwell_count), vecs[i].dw);
      chk($sformatf("v%0d trans_count", i), 32'(bus.trans_count), vecs[i].tc);
      chk($sformatf("v%0d stuck", i), 32'(bus.stuck), 0);
    end
    bus.clear = 1'b0;
    bus.sample_valid = 1'b1;
    bus.state_in = 2'd2;
    for (int i = 2; i <= 200; i++) begin
      tick();
      if (i == 199) chk("stuck below limit", 32'(bus.stuck), 0);
    end
    chk("dwell at limit", 32'(bus.dwell_count), 200);
    chk("stuck at limit", 32'(bus.stuck), 1);
    tick();
    chk("dwell past limit", 32'(bus.dwell_count), 201);
    chk("stuck past limit", 32'(bus.stuck), 1);
    bus.state_in = 2'd0;
    tick();
    chk("unstick trans_valid", 32'(bus.trans_valid), 1);
    chk("unstick from", 32'(bus.trans_from), 2);
    chk("unstick to", 32'(bus.trans_to), 0);
    chk("unstick illegal", 32'(bus.illegal), 0);
    chk("unstick dwell", 32'(bus.dwell_count), 0);
    chk("unstick stuck", 32'(bus.stuck), 0);
    chk("unstick trans_count", 32'(bus.trans_count), 2);
    for (int i = 0; i < 260; i++) tick();
    chk("dwell saturates", 32'(bus.dwell_count), 255);
    chk("stuck when saturated", 32'(bus.stuck), 1);
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    tick();
    rst = 1'b0;
    bus.state_in = 2'd1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      bus.sample_valid = 1'b1;
      tick();
      seen += int'(bus.trans_valid) + int'(bus.illegal);
      bus.sample_valid = 1'b0;
      tick();
      seen += int'(bus.trans_valid) + int'(bus.illegal);
    end
    chk("gap dwell_count", 32'(bus.dwell_count), 9);
    chk("gap pulses", 32'(seen), 0);
    chk("gap trans_count", 32'(bus.trans_count), 0);
    bus.legal_mask = 16'hBF77;
    bus.sample_valid = 1'b1;
    bus.state_in = 2'd3;
    rst = 1'b1;
    tick();
    check_zero("rst_mid");
    rst = 1'b0;
    tick();
    chk("reload trans_valid", 32'(bus.trans_valid), 0);
    chk("reload illegal", 32'(bus.illegal), 0);
    chk("reload dwell", 32'(bus.dwell_count), 0);
    chk("reload trans_count", 32'(bus.trans_count), 0);
    tick();
    chk("reload dwell next", 32'(bus.dwell_count), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fsm_transition_monitor.md
Name: fsm_transition_monitor

Overview:
- Observes the state bus of a generated FSM and decodes it back into transition events: for each cycle, which from->to arc (if any) the FSM took.
- Checks each transition against a legal-arc mask, captures the first illegal arc, tracks dwell time, and flags a stuck FSM.
- Sits beside any FSM instance. It is the inverse of the FSM logic, which turns transition conditions into a state; this block turns observed states back into transitions.
- Used by verification harnesses and by on-chip debug.

Parameters:
- STATE_W, 2, width of the observed state bus.
- NUM_STATES, 4, number of encoded states. Must satisfy NUM_STATES <= 2**STATE_W.
- CNT_W, 8, width of the dwell and transition counters. Both counters saturate.
- STUCK_LIMIT, 200, dwell cycles after which stuck is raised. Must be < 2**CNT_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- sample_valid  in  1  state_in is meaningful this cycle
- state_in  in  STATE_W  observed FSM state
- legal_mask  in  NUM_STATES*NUM_STATES  bit (f*NUM_STATES+t) = 1 means arc f->t is legal; self-loops are always legal
- clear  in  1  clears counters and sticky flags without a full reset
- trans_valid  out  1  one-cycle pulse: a transition was decoded
- trans_from  out  STATE_W  source state of the last decoded transition
- trans_to  out  STATE_W  destination state of the last decoded transition
- illegal  out  1  one-cycle pulse: decoded arc is not in legal_mask, or state_in >= NUM_STATES
- illegal_sticky  out  1  set by illegal, held until rst or clear
- first_bad_from  out  STATE_W  arc captured on the first illegal event
- first_bad_to  out  STATE_W  arc captured on the first illegal event
- dwell_count  out  CNT_W  cycles spent in the current state
- trans_count  out  CNT_W  total decoded transitions, saturating
- stuck  out  1  high while dwell_count >= STUCK_LIMIT

Behaviour:
- Clocking: all logic on posedge clk. rst is synchronous, active-high, and has priority over clear and sample_valid.
- Reset values: every output is 0. The internal FSM is in EMPTY. The prev_state register is 0.
- Internal FSM states:
  - EMPTY: no reference sample held yet.
  - TRACK: prev_state is valid.
- In EMPTY with sample_valid=1:
  - Load prev_state <= state_in and move to TRACK.
  - No trans_valid. dwell_count <= 0.
  - If state_in >= NUM_STATES, assert illegal, using from=to=state_in.
- In TRACK with sample_valid=1:
  - If state_in == prev_state: dwell_count increments, saturating at 2**CNT_W-1.
  - Otherwise:
    - trans_valid=1 and trans_from/trans_to = prev_state/state_in, registered (outputs change the cycle after the sample).
    - prev_state <= state_in, dwell_count <= 0, trans_count increments, saturating.
- Any cycle with sample_valid=0: no state change. Counters hold and no pulses are generated (the cycle is a gap, not a dwell).
- Illegal check:
  - Performed on every decoded transition, and also on out-of-range state_in when state_in == prev_state.
  - illegal is the registered pulse, with the same latency as trans_valid.
  - On the first illegal event while illegal_sticky=0, capture first_bad_from/first_bad_to. Later illegal events do not overwrite the capture.
- stuck is combinational from dwell_count >= STUCK_LIMIT. It clears the cycle after a transition resets dwell_count.
- clear (without rst):
  - Zeroes trans_count, illegal_sticky, first_bad_*, and dwell_count.
  - Keeps the FSM in TRACK with prev_state intact.
  - If clear and a transition coincide, the transition is reported (trans_valid, illegal pulse) and counters end at trans_count=1, dwell=0. The sticky flag and capture are set from that same-cycle illegal arc.
- rst mid-operation: everything returns to reset values next cycle. Any pulse pending that cycle is dropped.
- trans_from/trans_to hold their last values between pulses.

Decomposition:
- Shared package holds:
  - the monitor state enum {EMPTY, TRACK};
  - a typedef for the transition record {from, to};
  - a helper function arc_index(from, to) returning from*NUM_STATES+to.
- One sub-module, sat_counter (parameter W; inputs inc, clr; output value, saturating). It is instantiated twice, for dwell_count and trans_count.

Test Plan:
1. Reset, then sample_valid=1 with state_in 0,0,1 and legal_mask bit1 set -> trans_valid pulses once with from=0, to=1. illegal=0, trans_count=1, dwell_count=0.
2. Arc 0->3 with bit3 of legal_mask clear -> illegal pulse and illegal_sticky=1, first_bad=0/3. A later illegal 3->2 leaves first_bad at 0/3.
3. Hold state 2 for 201 valid cycles -> stuck rises when dwell_count reaches 200. A 2->0 transition drops stuck on the following cycle.
4. Alternate sample_valid 1/0 with a constant state for 10 valid cycles -> dwell_count=9 (the first valid cycle is the reference load), not 19. No pulses.
5. Assert clear in the same cycle as a legal 1->2 transition with trans_count=5 -> trans_valid pulses, trans_count=1, dwell_count=0, illegal_sticky=0.
6. Assert rst during an illegal transition cycle -> no illegal pulse, all outputs 0. The next valid sample reloads the reference with no trans_valid.
